// File: rtl/min_sec_pkg.sv
// Shared definitions for the MM:SS counter: run/stop state encoding, BCD digit width and
// the single-digit BCD increment used by the two-digit counters.
package min_sec_pkg;

  localparam int BCD_W = 4;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  // Next value of one BCD digit; 9 rolls to 0 and the caller handles the carry.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] digit);
    if (digit >= 4'd9) begin
      return '0;
    end
    return digit + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that counts 00..MAX and wraps to 00 on the enable after MAX.
// at_max is combinational so the parent can chain a carry in the same edge.
module bcd_mod_counter
  import min_sec_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] ones,
  output logic [BCD_W-1:0] tens,
  output logic             at_max
);

  localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'(MAX / 10);
  localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'(MAX % 10);

  assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ones <= '0;
      tens <= '0;
    end else if (en) begin
      if (at_max) begin
        ones <= '0;
        tens <= '0;
      end else if (ones == 4'd9) begin
        ones <= '0;
        tens <= bcd_inc(tens);
      end else begin
        ones <= bcd_inc(ones);
      end
    end
  end

endmodule

// File: rtl/min_sec_counter.sv
// MM:SS time-of-run counter driven by a 1 Hz enable on the 50 MHz clock, with run/stop,
// clear and manual adjust while stopped. Outputs four BCD digits plus a rollover pulse.
module min_sec_counter
  import min_sec_pkg::*;
#(
  parameter int SEC_MAX       = 59,
  parameter int MIN_MAX       = 59,
  parameter bit START_RUNNING = 1'b0
) (
  input  logic             clk_50mhz,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             run_toggle,
  input  logic             clear,
  input  logic             inc_sec,
  input  logic             inc_min,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             running,
  output logic             wrap_tick
);

  localparam state_t RESET_STATE = START_RUNNING ? ST_RUNNING : ST_STOPPED;

  state_t state, state_next;
  logic   sec_at_max, min_at_max;
  logic   count_tick, sec_en, min_en, wrap_next;

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (run_toggle) begin
      state_next = (state == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
    end
  end

  always_comb begin
    running = (state == ST_RUNNING);
  end

  // Enables use the pre-edge state; clear suppresses every count/adjust source.
  always_comb begin
    count_tick = (state == ST_RUNNING) && tick_1hz && !clear;
    sec_en     = count_tick || ((state == ST_STOPPED) && inc_sec && !clear);
    min_en     = (count_tick && sec_at_max) || ((state == ST_STOPPED) && inc_min && !clear);
    wrap_next  = count_tick && sec_at_max && min_at_max;
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk    (clk_50mhz),
    .reset  (reset),
    .clr    (clear),
    .en     (sec_en),
    .ones   (sec_ones),
    .tens   (sec_tens),
    .at_max (sec_at_max)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk    (clk_50mhz),
    .reset  (reset),
    .clr    (clear),
    .en     (min_en),
    .ones   (min_ones),
    .tens   (min_tens),
    .at_max (min_at_max)
  );

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      wrap_tick <= 1'b0;
    end else begin
      wrap_tick <= wrap_next;
    end
  end

endmodule

// File: tb/tb_min_sec_counter.sv
// Bench for min_sec_counter: directed scenarios then random pulses, every cycle compared
// against an integer minutes/seconds reference model.
module tb_min_sec_counter;

  localparam int SEC_MAX       = 59;
  localparam int MIN_MAX       = 59;
  localparam bit START_RUNNING = 1'b0;

  logic       clk_50mhz = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       run_toggle = 1'b0;
  logic       clear = 1'b0;
  logic       inc_sec = 1'b0;
  logic       inc_min = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, wrap_tick;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_sec = 0;
  int m_min = 0;
  bit m_run = START_RUNNING;
  bit m_wrap = 1'b0;

  min_sec_counter #(
    .SEC_MAX       (SEC_MAX),
    .MIN_MAX       (MIN_MAX),
    .START_RUNNING (START_RUNNING)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .run_toggle (run_toggle),
    .clear      (clear),
    .inc_sec    (inc_sec),
    .inc_min    (inc_min),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .running    (running),
    .wrap_tick  (wrap_tick)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_bcd4(input int mins, input int secs);
    return ((mins / 10) << 12) | ((mins % 10) << 8) | ((secs / 10) << 4) | (secs % 10);
  endfunction

  task automatic model_edge(input bit rst, input bit tk, input bit rt, input bit clr,
                            input bit is, input bit im);
    if (rst) begin
      m_sec = 0; m_min = 0; m_run = START_RUNNING; m_wrap = 1'b0;
      return;
    end
    m_wrap = 1'b0;
    if (clr) begin
      m_sec = 0; m_min = 0;
    end else if (m_run) begin
      if (tk) begin
        if (m_sec == SEC_MAX) begin
          m_sec = 0;
          if (m_min == MIN_MAX) begin
            m_min = 0; m_wrap = 1'b1;
          end else begin
            m_min++;
          end
        end else begin
          m_sec++;
        end
      end
    end else begin
      if (is) m_sec = (m_sec == SEC_MAX) ? 0 : m_sec + 1;
      if (im) m_min = (m_min == MIN_MAX) ? 0 : m_min + 1;
    end
    if (rt) m_run = !m_run;
  endtask

  // One clock edge with the given pulses; outputs compared 1 ns after the edge.
  task automatic step(input string tag, input bit rst, input bit tk, input bit rt,
                      input bit clr, input bit is, input bit im);
    reset = rst; tick_1hz = tk; run_toggle = rt; clear = clr; inc_sec = is; inc_min = im;
    model_edge(rst, tk, rt, clr, is, im);
    @(posedge clk_50mhz);
    #1;
    reset = 0; tick_1hz = 0; run_toggle = 0; clear = 0; inc_sec = 0; inc_min = 0;
    check_eq({tag, "_time"}, int'({min_tens, min_ones, sec_tens, sec_ones}), to_bcd4(m_min, m_sec));
    check_eq({tag, "_running"}, int'(running), int'(m_run));
    check_eq({tag, "_wrap"}, int'(wrap_tick), int'(m_wrap));
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic preload(input int mins, input int secs);
    if (m_run) step("pre_stop", 0, 0, 1, 0, 0, 0);
    step("pre_clr", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < mins; i++) step("pre_min", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < secs; i++) step("pre_sec", 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    #5;
    // 1: reset, ticks ignored while stopped, then run and count three
    step("rst", 1, 0, 0, 0, 0, 0);
    check_eq("rst_digits", int'({min_tens, min_ones, sec_tens, sec_ones}), 0);
    check_eq("rst_running", int'(running), int'(START_RUNNING));
    for (int i = 0; i < 5; i++) step("t1_stopped_tick", 0, 1, 0, 0, 0, 0);
    step("t1_run", 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t1_tick", 0, 1, 0, 0, 0, 0);
    check_eq("t1_0003", int'({min_tens, min_ones, sec_tens, sec_ones}), 16'h0003);

    // 2: 00:59 -> 01:00 without wrap
    preload(0, 59);
    step("t2_run", 0, 0, 1, 0, 0, 0);
    step("t2_tick", 0, 1, 0, 0, 0, 0);
    check_eq("t2_0100", int'({min_tens, min_ones, sec_tens, sec_ones}), 16'h0100);

    // 3: 59:59 -> 00:00 with a single-cycle wrap pulse
    preload(59, 59);
    step("t3_run", 0, 0, 1, 0, 0, 0);
    step("t3_tick", 0, 1, 0, 0, 0, 0);
    check_eq("t3_wrap_hi", int'(wrap_tick), 1);
    idle("t3_after");
    check_eq("t3_wrap_lo", int'(wrap_tick), 0);

    // 4: clear beats a coincident tick
    preload(0, 10);
    step("t4_run", 0, 0, 1, 0, 0, 0);
    step("t4_clr_tick", 0, 1, 0, 1, 0, 0);
    step("t4_tick", 0, 1, 0, 0, 0, 0);
    check_eq("t4_0001", int'({min_tens, min_ones, sec_tens, sec_ones}), 16'h0001);

    // 5: manual adjust: no carry, minute wrap without pulse, ignored while running
    preload(58, 59);
    step("t5_inc_sec", 0, 0, 0, 0, 1, 0);
    check_eq("t5_5800", int'({min_tens, min_ones, sec_tens, sec_ones}), 16'h5800);
    step("t5_inc_min", 0, 0, 0, 0, 0, 1);
    step("t5_inc_min", 0, 0, 0, 0, 0, 1);
    check_eq("t5_0000", int'({min_tens, min_ones, sec_tens, sec_ones}), 16'h0000);
    step("t5_both", 0, 0, 0, 0, 1, 1);
    step("t5_run", 0, 0, 1, 0, 0, 0);
    step("t5_inc_run", 0, 0, 0, 0, 1, 1);
    check_eq("t5_0101", int'({min_tens, min_ones, sec_tens, sec_ones}), 16'h0101);

    // 6: tick with run_toggle counts; reset mid-count
    preload(12, 34);
    step("t6_run", 0, 0, 1, 0, 0, 0);
    step("t6_tick_toggle", 0, 1, 1, 0, 0, 0);
    check_eq("t6_1235", int'({min_tens, min_ones, sec_tens, sec_ones}), 16'h1235);
    check_eq("t6_stopped", int'(running), 0);
    step("t6_run2", 0, 0, 1, 0, 0, 0);
    step("t6_tick_rst", 1, 1, 1, 0, 1, 1);
    check_eq("t6_rst", int'({min_tens, min_ones, sec_tens, sec_ones}), 0);
    step("t6_run3", 0, 0, 1, 0, 0, 0);
    step("t6_resume", 0, 1, 0, 0, 0, 0);

    // Random pulses; tick is dense so rollovers occur
    for (int i = 0; i < 6000; i++) begin
      step("rnd",
           $urandom_range(0, 499) == 0,
           $urandom_range(0, 1) == 0,
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 600) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
